// File: rtl/fault_input_conditioner_if.sv
// Board-facing signal bundle of the fault input conditioner: raw pushbuttons
// in, conditioned reset/fault controls and debug levels out.
interface fault_input_conditioner_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   btn_rst_raw;
  logic                   btn_fault_raw;
  logic                   rst_n_out;
  logic                   fault_out;
  logic                   btn_rst_db;
  logic                   btn_fault_db;
  logic [1:0]             fault_state;
  logic [COUNT_WIDTH-1:0] fault_count;

  // Board / stimulus side: drives the buttons, observes the conditioned outputs.
  modport master (
    output btn_rst_raw, btn_fault_raw,
    input  rst_n_out, fault_out, btn_rst_db, btn_fault_db, fault_state, fault_count
  );

  // Conditioner side.
  modport slave (
    input  btn_rst_raw, btn_fault_raw,
    output rst_n_out, fault_out, btn_rst_db, btn_fault_db, fault_state, fault_count
  );
endinterface

// File: rtl/fault_input_conditioner.sv
// Conditions the raw reset and fault pushbuttons for the burst PWM generator:
// 2-flop synchronizers, ms-tick debouncers, a reset pulse stretcher and a
// fault FSM with minimum-duration and optional latching policy.
module fault_input_conditioner #(
  parameter int CLK_SISTEMA_FREQ = 12_000_000,
  parameter int DEBOUNCE_MS      = 20,
  parameter int FAULT_MIN_MS     = 500,
  parameter int FAULT_LATCH      = 1,
  parameter int RST_PULSE_CYCLES = 16,
  parameter int BTN_ACTIVE_LOW   = 1,
  parameter int COUNT_WIDTH      = 8
) (
  input logic                       clk,
  input logic                       rst,
  fault_input_conditioner_if.slave  bus
);

  localparam int   MS_PERIOD = CLK_SISTEMA_FREQ / 1000;
  localparam int   MS_W      = (MS_PERIOD > 1) ? $clog2(MS_PERIOD) : 1;
  localparam int   DB_W      = $clog2(DEBOUNCE_MS + 1);
  localparam int   MIN_W     = $clog2(FAULT_MIN_MS + 1);
  localparam int   PULSE_W   = $clog2(RST_PULSE_CYCLES + 1);
  // Raw level of a released button.
  localparam logic BTN_IDLE  = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLD    = 2'd2,
    LATCHED = 2'd3
  } fault_state_e;

  // Bit 0 of every per-button vector is the reset button, bit 1 the fault button.
  logic [MS_W-1:0]            ms_cnt_q, ms_cnt_d;
  logic                       ms_tick;
  logic [1:0]                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]                 pressed;
  logic [1:0]                 db_q, db_d, db_prev_q, db_prev_d;
  logic [1:0][DB_W-1:0]       stab_q, stab_d;
  logic [1:0]                 press_evt;
  logic [PULSE_W-1:0]         pulse_q, pulse_d;
  logic                       rst_n_q, rst_n_d;
  fault_state_e               state_q, state_d;
  logic [MIN_W-1:0]           min_q, min_d;
  logic [COUNT_WIDTH-1:0]     count_q, count_d;
  logic                       fault_q, fault_d;

  assign ms_tick   = (ms_cnt_q == MS_W'(MS_PERIOD - 1));
  assign pressed   = sync2_q ^ {2{BTN_IDLE}};
  assign press_evt = db_q & ~db_prev_q;

  // ms timebase, button synchronizers and per-button debounce counters.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    ms_cnt_d  = ms_tick ? '0 : ms_cnt_q + MS_W'(1);
    sync1_d   = {bus.btn_fault_raw, bus.btn_rst_raw};
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    stab_d    = stab_q;
    for (int i = 0; i < 2; i++) begin
      if (pressed[i] == db_q[i]) begin
        stab_d[i] = '0;
      end else if (ms_tick) begin
        if (stab_q[i] == DB_W'(DEBOUNCE_MS - 1)) begin
          db_d[i]   = pressed[i];
          stab_d[i] = '0;
        end else begin
          stab_d[i] = stab_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Reset pulse stretcher: a press (re)loads the remaining low-cycle count.
  always_comb begin
    if (press_evt[0]) begin
      pulse_d = PULSE_W'(RST_PULSE_CYCLES);
    end else if (pulse_q != '0) begin
      pulse_d = pulse_q - PULSE_W'(1);
    end else begin
      pulse_d = pulse_q;
    end
    rst_n_d = (pulse_d == '0);
  end

  // Fault FSM next state, minimum-duration timer and saturating entry counter.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (press_evt[1]) begin
          state_d = ACTIVE;
          min_d   = '0;
          if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
        end
      end
      ACTIVE: begin
        if (ms_tick) begin
          if (min_q == MIN_W'(FAULT_MIN_MS - 1)) begin
            min_d = '0;
            if (FAULT_LATCH != 0) state_d = LATCHED;
            else if (db_q[1])     state_d = HOLD;
            else                  state_d = IDLE;
          end else begin
            min_d = min_q + MIN_W'(1);
          end
        end
      end
      HOLD: begin
        if (!db_q[1]) state_d = IDLE;
      end
      LATCHED: begin
        if (press_evt[0] && !db_q[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    fault_d = (state_d != IDLE);
  end

  // State registers with synchronous reset; synchronizers reload the released level.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (rst) begin
      ms_cnt_q  <= '0;
      sync1_q   <= {2{BTN_IDLE}};
      sync2_q   <= {2{BTN_IDLE}};
      db_q      <= '0;
      db_prev_q <= '0;
      stab_q    <= '0;
      pulse_q   <= PULSE_W'(RST_PULSE_CYCLES);
      rst_n_q   <= 1'b0;
      state_q   <= IDLE;
      min_q     <= '0;
      count_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      ms_cnt_q  <= ms_cnt_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      stab_q    <= stab_d;
      pulse_q   <= pulse_d;
      rst_n_q   <= rst_n_d;
      state_q   <= state_d;
      min_q     <= min_d;
      count_q   <= count_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.rst_n_out    = rst_n_q;
  assign bus.fault_out    = fault_q;
  assign bus.btn_rst_db   = db_q[0];
  assign bus.btn_fault_db = db_q[1];
  assign bus.fault_state  = state_q;
  assign bus.fault_count  = count_q;

endmodule

// File: tb/tb_fault_input_conditioner.sv
// Bench for fault_input_conditioner: one latching instance (COUNT_WIDTH=2) and
// one self-clearing instance (COUNT_WIDTH=8) share clock, reset and buttons.
module tb_fault_input_conditioner;

  localparam int CLK_FREQ = 10_000;
  localparam int P        = CLK_FREQ / 1000;
  localparam int DB_MS    = 3;
  localparam int MIN_MS   = 5;
  localparam int PULSE    = 4;

  localparam int SEL_RST_DB   = 0;
  localparam int SEL_FAULT_DB = 1;
  localparam int SEL_L_STATE  = 2;
  localparam int SEL_S_STATE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_rst = 1'b1;    // buttons are active-low: 1 = released
  logic raw_fault = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fault_input_conditioner_if #(.COUNT_WIDTH(2)) if_l ();
  fault_input_conditioner_if #(.COUNT_WIDTH(8)) if_s ();

  assign if_l.btn_rst_raw   = raw_rst;
  assign if_l.btn_fault_raw = raw_fault;
  assign if_s.btn_rst_raw   = raw_rst;
  assign if_s.btn_fault_raw = raw_fault;

  fault_input_conditioner #(
    .CLK_SISTEMA_FREQ(CLK_FREQ), .DEBOUNCE_MS(DB_MS), .FAULT_MIN_MS(MIN_MS),
    .FAULT_LATCH(1), .RST_PULSE_CYCLES(PULSE), .BTN_ACTIVE_LOW(1), .COUNT_WIDTH(2)
  ) u_latch (.clk(clk), .rst(rst), .bus(if_l));

  fault_input_conditioner #(
    .CLK_SISTEMA_FREQ(CLK_FREQ), .DEBOUNCE_MS(DB_MS), .FAULT_MIN_MS(MIN_MS),
    .FAULT_LATCH(0), .RST_PULSE_CYCLES(PULSE), .BTN_ACTIVE_LOW(1), .COUNT_WIDTH(8)
  ) u_self (.clk(clk), .rst(rst), .bus(if_s));

  // ---------------------------------------------------------------------------
  // Reference model: button index 0 = reset, 1 = fault; instance 0 latches,
  // instance 1 self-clears. States: 0 idle, 1 active, 2 hold, 3 latched.
  // ---------------------------------------------------------------------------
  int m_cyc;
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_db [2];
  bit m_prev [2];
  int m_stab [2];
  int m_rem;
  bit m_rstn;
  int m_st [2];
  int m_tmr [2];
  int m_cnt [2];
  bit m_fo [2];

  always @(posedge clk) begin
    if (rst) begin
      m_cyc  <= 0;
      m_rem  <= PULSE;
      m_rstn <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] <= 1'b0; m_s2[b] <= 1'b0; m_db[b] <= 1'b0;
        m_prev[b] <= 1'b0; m_stab[b] <= 0;
        m_st[b] <= 0; m_tmr[b] <= 0; m_cnt[b] <= 0; m_fo[b] <= 1'b0;
      end
    end else begin
      automatic bit tick = ((m_cyc % P) == P - 1);
      automatic bit press [2];
      automatic bit now_pressed [2];
      automatic int rem_n;
      now_pressed[0] = !raw_rst;
      now_pressed[1] = !raw_fault;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] <= now_pressed[b];
        m_s2[b] <= m_s1[b];
        if (m_s2[b] == m_db[b]) m_stab[b] <= 0;
        else if (tick) begin
          if (m_stab[b] + 1 >= DB_MS) begin
            m_db[b] <= m_s2[b];
            m_stab[b] <= 0;
          end else m_stab[b] <= m_stab[b] + 1;
        end
        press[b] = m_db[b] && !m_prev[b];
        m_prev[b] <= m_db[b];
      end
      rem_n = press[0] ? PULSE : ((m_rem > 0) ? m_rem - 1 : 0);
      m_rem  <= rem_n;
      m_rstn <= (rem_n == 0);
      for (int i = 0; i < 2; i++) begin
        automatic int nxt = m_st[i];
        automatic int cmax = (i == 0) ? 3 : 255;
        if (m_st[i] == 0 && press[1]) begin
          nxt = 1;
          m_tmr[i] <= 0;
          m_cnt[i] <= (m_cnt[i] < cmax) ? m_cnt[i] + 1 : cmax;
        end else if (m_st[i] == 1 && tick) begin
          if (m_tmr[i] + 1 >= MIN_MS) begin
            nxt = (i == 0) ? 3 : (m_db[1] ? 2 : 0);
            m_tmr[i] <= 0;
          end else m_tmr[i] <= m_tmr[i] + 1;
        end else if (m_st[i] == 2 && !m_db[1]) begin
          nxt = 0;
        end else if (m_st[i] == 3 && press[0] && !m_db[1]) begin
          nxt = 0;
        end
        m_st[i] <= nxt;
        m_fo[i] <= (nxt != 0);
      end
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int probe(input int sel);
    case (sel)
      SEL_RST_DB:   return int'(if_l.btn_rst_db);
      SEL_FAULT_DB: return int'(if_l.btn_fault_db);
      SEL_L_STATE:  return int'(if_l.fault_state);
      SEL_S_STATE:  return int'(if_s.fault_state);
      default:      return int'(if_l.rst_n_out);
    endcase
  endfunction

  // Bounded wait; an expired bound counts as a failed comparison.
  task automatic wait_for(input int sel, input int val, input int max_cyc, input string what);
    int n = 0;
    while (probe(sel) != val && n < max_cyc) begin
      step(1);
      n++;
    end
    n_checks++;
    if (probe(sel) != val) begin
      n_errors++;
      $display("FAIL timeout_%s: value %0d after %0d cycles, required %0d", what, probe(sel), n, val);
    end
  endtask

  // Number of consecutive negedge samples (starting now) with rst_n_out low.
  task automatic count_low(output int n);
    n = 0;
    while (if_l.rst_n_out === 1'b0 && n < 50) begin
      n++;
      step(1);
    end
  endtask

  task automatic do_reset();
    raw_rst = 1'b1; raw_fault = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(PULSE + 2);
  endtask

  task automatic clear_latch();
    raw_rst = 1'b0;
    wait_for(SEL_RST_DB, 1, 60, "clr_rst_db_rise");
    raw_rst = 1'b1;
    wait_for(SEL_RST_DB, 0, 60, "clr_rst_db_fall");
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    rst = 1'b1;
    step(3);
    n_checks++; if (if_l.rst_n_out !== 1'b0)  begin n_errors++; $display("FAIL reset_rst_n_l got %b want 0", if_l.rst_n_out); end
    n_checks++; if (if_s.rst_n_out !== 1'b0)  begin n_errors++; $display("FAIL reset_rst_n_s got %b want 0", if_s.rst_n_out); end
    n_checks++; if (if_l.fault_out !== 1'b0)  begin n_errors++; $display("FAIL reset_fault_l got %b want 0", if_l.fault_out); end
    n_checks++; if (if_s.fault_out !== 1'b0)  begin n_errors++; $display("FAIL reset_fault_s got %b want 0", if_s.fault_out); end
    n_checks++; if (if_l.btn_rst_db !== 1'b0) begin n_errors++; $display("FAIL reset_rst_db got %b want 0", if_l.btn_rst_db); end
    n_checks++; if (if_l.btn_fault_db !== 1'b0) begin n_errors++; $display("FAIL reset_fault_db got %b want 0", if_l.btn_fault_db); end
    n_checks++; if (if_l.fault_state !== 2'd0) begin n_errors++; $display("FAIL reset_state_l got %0d want 0", if_l.fault_state); end
    n_checks++; if (if_s.fault_state !== 2'd0) begin n_errors++; $display("FAIL reset_state_s got %0d want 0", if_s.fault_state); end
    n_checks++; if (if_l.fault_count !== 2'd0) begin n_errors++; $display("FAIL reset_count_l got %0d want 0", if_l.fault_count); end
    n_checks++; if (if_s.fault_count !== 8'd0) begin n_errors++; $display("FAIL reset_count_s got %0d want 0", if_s.fault_count); end
    rst = 1'b0;
    count_low(n);
    n_checks++; if (n != PULSE) begin n_errors++; $display("FAIL reset_pulse_len got %0d want %0d", n, PULSE); end
    n_checks++; if (if_s.rst_n_out !== 1'b1) begin n_errors++; $display("FAIL reset_pulse_end_s got %b want 1", if_s.rst_n_out); end
  endtask

  task automatic test_bounce();
    int n;
    for (int k = 0; k < 12; k++) begin
      raw_fault = ~raw_fault;
      for (int c = 0; c < 5; c++) begin
        step(1);
        n_checks++;
        if (if_s.btn_fault_db !== 1'b0) begin
          n_errors++; $display("FAIL bounce_db_low slot %0d got %b want 0", k, if_s.btn_fault_db);
        end
      end
    end
    raw_fault = 1'b0;
    n = 0;
    while (if_s.btn_fault_db !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    n_checks++; if (n < 23 || n > 32) begin n_errors++; $display("FAIL bounce_latency got %0d want 23..32", n); end
    n_checks++; if (if_l.fault_state !== 2'd0) begin n_errors++; $display("FAIL bounce_state_pre got %0d want 0", if_l.fault_state); end
    step(1);
    n_checks++; if (if_l.fault_state !== 2'd1) begin n_errors++; $display("FAIL bounce_state_l got %0d want 1", if_l.fault_state); end
    n_checks++; if (if_s.fault_state !== 2'd1) begin n_errors++; $display("FAIL bounce_state_s got %0d want 1", if_s.fault_state); end
    n_checks++; if (if_l.fault_count !== 2'd1) begin n_errors++; $display("FAIL bounce_count_l got %0d want 1", if_l.fault_count); end
    n_checks++; if (if_s.fault_count !== 8'd1) begin n_errors++; $display("FAIL bounce_count_s got %0d want 1", if_s.fault_count); end
    raw_fault = 1'b1;
    wait_for(SEL_FAULT_DB, 0, 60, "bounce_db_fall");
    wait_for(SEL_L_STATE, 3, 80, "bounce_latched");
    clear_latch();
  endtask

  task automatic test_latch();
    int n;
    int n_act = 0;
    int drop = 0;
    do_reset();
    raw_fault = 1'b0;
    wait_for(SEL_FAULT_DB, 1, 60, "latch_db_rise");
    for (int c = 0; c < 70; c++) begin
      step(1);
      if (if_l.fault_state === 2'd1) n_act++;
      if (if_l.fault_out !== 1'b1) drop++;
    end
    n_checks++; if (if_l.fault_state !== 2'd3) begin n_errors++; $display("FAIL latch_state got %0d want 3", if_l.fault_state); end
    n_checks++; if (n_act < 41 || n_act > 50) begin n_errors++; $display("FAIL latch_active_len got %0d want 41..50", n_act); end
    n_checks++; if (drop != 0) begin n_errors++; $display("FAIL latch_fault_drop got %0d low cycles want 0", drop); end
    n_checks++; if (if_s.fault_state !== 2'd2) begin n_errors++; $display("FAIL latch_self_hold got %0d want 2", if_s.fault_state); end
    raw_fault = 1'b1;
    wait_for(SEL_FAULT_DB, 0, 60, "latch_db_fall");
    step(5);
    n_checks++; if (if_l.fault_out !== 1'b1) begin n_errors++; $display("FAIL latch_held_out got %b want 1", if_l.fault_out); end
    n_checks++; if (if_l.fault_state !== 2'd3) begin n_errors++; $display("FAIL latch_held_state got %0d want 3", if_l.fault_state); end
    n_checks++; if (if_s.fault_out !== 1'b0) begin n_errors++; $display("FAIL latch_self_out got %b want 0", if_s.fault_out); end
    raw_rst = 1'b0;
    wait_for(SEL_RST_DB, 1, 60, "latch_rst_db_rise");
    n_checks++; if (if_l.rst_n_out !== 1'b1) begin n_errors++; $display("FAIL latch_rst_n_early got %b want 1", if_l.rst_n_out); end
    n_checks++; if (if_l.fault_state !== 2'd3) begin n_errors++; $display("FAIL latch_state_early got %0d want 3", if_l.fault_state); end
    step(1);
    n_checks++; if (if_l.fault_state !== 2'd0) begin n_errors++; $display("FAIL latch_cleared got %0d want 0", if_l.fault_state); end
    n_checks++; if (if_l.fault_out !== 1'b0) begin n_errors++; $display("FAIL latch_cleared_out got %b want 0", if_l.fault_out); end
    count_low(n);
    n_checks++; if (n != PULSE) begin n_errors++; $display("FAIL latch_pulse_len got %0d want %0d", n, PULSE); end
    n_checks++; if (if_l.fault_count !== 2'd1) begin n_errors++; $display("FAIL latch_count got %0d want 1", if_l.fault_count); end
    raw_rst = 1'b1;
    wait_for(SEL_RST_DB, 0, 60, "latch_rst_db_fall");
  endtask

  task automatic test_self_clear();
    int n = 0;
    do_reset();
    raw_fault = 1'b0;
    wait_for(SEL_FAULT_DB, 1, 60, "self_db_rise");
    raw_fault = 1'b1;
    step(1);
    while (if_s.fault_out === 1'b1 && n < 200) begin
      n++;
      step(1);
    end
    n_checks++; if (n < 41 || n > 50) begin n_errors++; $display("FAIL self_fault_len got %0d want 41..50", n); end
    n_checks++; if (if_s.fault_state !== 2'd0) begin n_errors++; $display("FAIL self_state_end got %0d want 0", if_s.fault_state); end
    wait_for(SEL_L_STATE, 3, 20, "self_latch_side");
    clear_latch();
  endtask

  task automatic test_hold();
    do_reset();
    raw_fault = 1'b0;
    wait_for(SEL_FAULT_DB, 1, 60, "hold_db_rise");
    step(1);
    n_checks++; if (if_s.fault_state !== 2'd1) begin n_errors++; $display("FAIL hold_active got %0d want 1", if_s.fault_state); end
    wait_for(SEL_S_STATE, 2, 80, "hold_enter");
    step(250);
    n_checks++; if (if_s.fault_out !== 1'b1) begin n_errors++; $display("FAIL hold_out got %b want 1", if_s.fault_out); end
    raw_fault = 1'b1;
    wait_for(SEL_FAULT_DB, 0, 60, "hold_db_fall");
    n_checks++; if (if_s.fault_out !== 1'b1) begin n_errors++; $display("FAIL hold_out_at_fall got %b want 1", if_s.fault_out); end
    step(1);
    n_checks++; if (if_s.fault_out !== 1'b0) begin n_errors++; $display("FAIL hold_out_after got %b want 0", if_s.fault_out); end
    n_checks++; if (if_s.fault_state !== 2'd0) begin n_errors++; $display("FAIL hold_state_after got %0d want 0", if_s.fault_state); end
    clear_latch();
  endtask

  task automatic test_latched_held();
    int n;
    do_reset();
    raw_fault = 1'b0;
    wait_for(SEL_FAULT_DB, 1, 60, "held_db_rise");
    wait_for(SEL_L_STATE, 3, 80, "held_latched");
    raw_rst = 1'b0;
    wait_for(SEL_RST_DB, 1, 60, "held_rst_db_rise");
    step(1);
    n_checks++; if (if_l.fault_state !== 2'd3) begin n_errors++; $display("FAIL held_state got %0d want 3", if_l.fault_state); end
    n_checks++; if (if_l.fault_out !== 1'b1) begin n_errors++; $display("FAIL held_out got %b want 1", if_l.fault_out); end
    n_checks++; if (if_l.rst_n_out !== 1'b0) begin n_errors++; $display("FAIL held_rst_n got %b want 0", if_l.rst_n_out); end
    count_low(n);
    n_checks++; if (n != PULSE) begin n_errors++; $display("FAIL held_pulse_len got %0d want %0d", n, PULSE); end
    raw_rst = 1'b1;
    raw_fault = 1'b1;
    wait_for(SEL_FAULT_DB, 0, 60, "held_db_fall");
    wait_for(SEL_RST_DB, 0, 60, "held_rst_db_fall");
    clear_latch();
    step(1);
    n_checks++; if (if_l.fault_state !== 2'd0) begin n_errors++; $display("FAIL held_final got %0d want 0", if_l.fault_state); end
  endtask

  task automatic test_saturate_and_rst();
    int n;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      raw_fault = 1'b0;
      wait_for(SEL_FAULT_DB, 1, 60, "sat_db_rise");
      raw_fault = 1'b1;
      wait_for(SEL_FAULT_DB, 0, 60, "sat_db_fall");
      wait_for(SEL_L_STATE, 3, 80, "sat_latched");
      clear_latch();
    end
    n_checks++; if (if_l.fault_count !== 2'd3) begin n_errors++; $display("FAIL sat_count_l got %0d want 3", if_l.fault_count); end
    n_checks++; if (if_s.fault_count !== 8'd5) begin n_errors++; $display("FAIL sat_count_s got %0d want 5", if_s.fault_count); end
    raw_fault = 1'b0;
    wait_for(SEL_FAULT_DB, 1, 60, "sat_db_rise2");
    step(1);
    n_checks++; if (if_l.fault_state !== 2'd1) begin n_errors++; $display("FAIL sat_active got %0d want 1", if_l.fault_state); end
    rst = 1'b1;
    raw_fault = 1'b1;
    step(1);
    n_checks++; if (if_l.fault_out !== 1'b0) begin n_errors++; $display("FAIL midrst_out_l got %b want 0", if_l.fault_out); end
    n_checks++; if (if_s.fault_out !== 1'b0) begin n_errors++; $display("FAIL midrst_out_s got %b want 0", if_s.fault_out); end
    n_checks++; if (if_l.fault_state !== 2'd0) begin n_errors++; $display("FAIL midrst_state got %0d want 0", if_l.fault_state); end
    n_checks++; if (if_l.fault_count !== 2'd0) begin n_errors++; $display("FAIL midrst_count_l got %0d want 0", if_l.fault_count); end
    n_checks++; if (if_s.fault_count !== 8'd0) begin n_errors++; $display("FAIL midrst_count_s got %0d want 0", if_s.fault_count); end
    n_checks++; if (if_l.rst_n_out !== 1'b0) begin n_errors++; $display("FAIL midrst_rst_n got %b want 0", if_l.rst_n_out); end
    step(1);
    rst = 1'b0;
    count_low(n);
    n_checks++; if (n != PULSE) begin n_errors++; $display("FAIL midrst_pulse_len got %0d want %0d", n, PULSE); end
  endtask

  task automatic test_random();
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      int len = $urandom_range(1, 60);
      rst       = ($urandom_range(0, 29) == 0);
      if (rst) len = $urandom_range(1, 3);
      raw_rst   = ($urandom_range(0, 2) != 0);
      raw_fault = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < len; c++) begin
        step(1);
        n_checks++; if (if_l.rst_n_out !== m_rstn) begin n_errors++; $display("FAIL rand_rst_n cyc %0d got %b want %b", m_cyc, if_l.rst_n_out, m_rstn); end
        n_checks++; if (if_l.btn_rst_db !== m_db[0]) begin n_errors++; $display("FAIL rand_rst_db cyc %0d got %b want %b", m_cyc, if_l.btn_rst_db, m_db[0]); end
        n_checks++; if (if_l.btn_fault_db !== m_db[1]) begin n_errors++; $display("FAIL rand_fault_db cyc %0d got %b want %b", m_cyc, if_l.btn_fault_db, m_db[1]); end
        n_checks++; if (if_l.fault_out !== m_fo[0]) begin n_errors++; $display("FAIL rand_fault_l cyc %0d got %b want %b", m_cyc, if_l.fault_out, m_fo[0]); end
        n_checks++; if (if_s.fault_out !== m_fo[1]) begin n_errors++; $display("FAIL rand_fault_s cyc %0d got %b want %b", m_cyc, if_s.fault_out, m_fo[1]); end
        n_checks++; if (if_l.fault_state !== 2'(m_st[0])) begin n_errors++; $display("FAIL rand_state_l cyc %0d got %0d want %0d", m_cyc, if_l.fault_state, m_st[0]); end
        n_checks++; if (if_s.fault_state !== 2'(m_st[1])) begin n_errors++; $display("FAIL rand_state_s cyc %0d got %0d want %0d", m_cyc, if_s.fault_state, m_st[1]); end
        n_checks++; if (if_l.fault_count !== 2'(m_cnt[0])) begin n_errors++; $display("FAIL rand_count_l cyc %0d got %0d want %0d", m_cyc, if_l.fault_count, m_cnt[0]); end
        n_checks++; if (if_s.fault_count !== 8'(m_cnt[1])) begin n_errors++; $display("FAIL rand_count_s cyc %0d got %0d want %0d", m_cyc, if_s.fault_count, m_cnt[1]); end
      end
    end
    rst = 1'b0;
    raw_rst = 1'b1;
    raw_fault = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(1);
    test_reset();
    test_bounce();
    test_latch();
    test_self_clear();
    test_hold();
    test_latched_held();
    test_saturate_and_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
